// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0800;
  localparam logic [4:0]         HALT_OPC  = 5'b00000;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DISCARD = 2'd1,
    HOLD    = 2'd2,
    HALTED  = 2'd3
  } fetch_state_t;

  function automatic logic is_halt(input logic [INSTR_W-1:0] instr, input logic [4:0] opc);
    return instr[INSTR_W-1:INSTR_W-5] == opc;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// Skid register holding one {instr, pc} pair while IF/ID is stalled.
module fetch_hold_buf
  import fetch_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] instr,
  input  logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] buf_instr,
  output logic [PC_W-1:0]    buf_pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_instr <= NOP_INSTR;
      buf_pc    <= '0;
    end else if (load) begin
      buf_instr <= instr;
      buf_pc    <= pc;
    end else if (clear) begin
      buf_instr <= NOP_INSTR;
      buf_pc    <= '0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, handshakes with imem, feeds IF/ID.
// Optional FETCH_STATS_EN adds delivered-instruction and bubble counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC  = 16'h0000,
  parameter logic [INSTR_W-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR,
  parameter logic [4:0]         HALT_OPC  = fetch_pkg::HALT_OPC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  output logic [INSTR_W-1:0] instrct_out,
  output logic [PC_W-1:0]    newPC_out,
  output logic [PC_W-1:0]    PC2_out,
  output logic               ifid_en,
  output logic               halted
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]        stat_fetched,
  output logic [15:0]        stat_bubbles
`endif
);

  fetch_state_t       state, state_next;
  logic [PC_W-1:0]    pc, pc_next;
  logic [PC_W-1:0]    redir_pc, redir_next;
  logic [INSTR_W-1:0] buf_instr;
  logic [PC_W-1:0]    buf_pc;
  logic               buf_load, buf_clear;
  logic               deliver;
  logic               req;
  logic [PC_W-1:0]    out_pc;

  fetch_hold_buf #(.NOP_INSTR(NOP_INSTR)) u_hold_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .clear     (buf_clear),
    .instr     (imem_rdata),
    .pc        (pc),
    .buf_instr (buf_instr),
    .buf_pc    (buf_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      redir_pc <= '0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      redir_pc <= redir_next;
    end
  end

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    redir_next  = redir_pc;
    buf_load    = 1'b0;
    buf_clear   = 1'b0;
    deliver     = 1'b0;
    req         = 1'b0;
    instrct_out = NOP_INSTR;
    out_pc      = pc;
    unique case (state)
      FETCH: begin
        req = 1'b1;
        if (imem_ready) begin
          if (redirect) begin
            pc_next = redirect_pc;
          end else if (stall) begin
            buf_load   = 1'b1;
            state_next = HOLD;
          end else begin
            deliver     = 1'b1;
            instrct_out = imem_rdata;
            if (is_halt(imem_rdata, HALT_OPC)) state_next = HALTED;
            else                               pc_next    = pc + 16'd2;
          end
        end else if (redirect) begin
          redir_next = redirect_pc;
          state_next = DISCARD;
        end
      end
      DISCARD: begin
        // imem_addr stays at pc: the outstanding request was issued from it
        req = 1'b1;
        if (redirect) redir_next = redirect_pc;
        if (imem_ready) begin
          pc_next    = redirect ? redirect_pc : redir_pc;
          state_next = FETCH;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_next    = redirect_pc;
          buf_clear  = 1'b1;
          state_next = FETCH;
        end else if (!stall) begin
          deliver     = 1'b1;
          instrct_out = buf_instr;
          out_pc      = buf_pc;
          buf_clear   = 1'b1;
          if (is_halt(buf_instr, HALT_OPC)) begin
            state_next = HALTED;
          end else begin
            pc_next    = pc + 16'd2;
            state_next = FETCH;
          end
        end
      end
      HALTED: begin
        if (redirect) begin
          pc_next    = redirect_pc;
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  // No request may be seen while reset is held
  assign imem_req  = req && !rst;
  assign imem_addr = pc;
  assign newPC_out = out_pc;
  assign PC2_out   = out_pc + 16'd2;
  assign ifid_en   = !stall || redirect;
  assign halted    = (state == HALTED);

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_fetched <= '0;
      stat_bubbles <= '0;
    end else begin
      if (deliver && stat_fetched != 16'hFFFF)
        stat_fetched <= stat_fetched + 16'd1;
      if (ifid_en && !deliver && stat_bubbles != 16'hFFFF)
        stat_bubbles <= stat_bubbles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage with hand-computed expectations.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirect, imem_ready;
  logic [15:0] redirect_pc, imem_rdata;
  logic        imem_req, ifid_en, halted;
  logic [15:0] imem_addr, instrct_out, newPC_out, PC2_out;
`ifdef FETCH_STATS_EN
  logic [15:0] stat_fetched, stat_bubbles;
`endif

  int errors = 0;
  int checks = 0;

  localparam logic [15:0] NOP = 16'h0800;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .instrct_out (instrct_out),
    .newPC_out   (newPC_out),
    .PC2_out     (PC2_out),
    .ifid_en     (ifid_en),
    .halted      (halted)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched (stat_fetched),
    .stat_bubbles (stat_bubbles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic rd, input logic [15:0] rpc,
                       input logic rdy, input logic [15:0] data);
    stall = st; redirect = rd; redirect_pc = rpc; imem_ready = rdy; imem_rdata = data;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    stall = 0; redirect = 0; redirect_pc = 0; imem_ready = 0; imem_rdata = 0;
    #2;
    chk("rst_req", {15'd0, imem_req}, 16'd0);
    chk("rst_instr", instrct_out, NOP);
    chk("rst_newpc", newPC_out, 16'h0000);
    chk("rst_pc2", PC2_out, 16'h0002);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    tick(); tick();
    rst = 1'b0;

    // back-to-back delivery, memory always ready
    drive(0, 0, 0, 1, 16'h4001);
    chk("b2b0_req", {15'd0, imem_req}, 16'd1);
    chk("b2b0_instr", instrct_out, 16'h4001);
    chk("b2b0_newpc", newPC_out, 16'h0000);
    chk("b2b0_pc2", PC2_out, 16'h0002);
    chk("b2b0_ifid", {15'd0, ifid_en}, 16'd1);
    tick(); drive(0, 0, 0, 1, 16'h4002);
    chk("b2b1_instr", instrct_out, 16'h4002);
    chk("b2b1_newpc", newPC_out, 16'h0002);
    chk("b2b1_pc2", PC2_out, 16'h0004);
    tick(); drive(0, 0, 0, 1, 16'h4003);
    chk("b2b2_instr", instrct_out, 16'h4003);
    chk("b2b2_newpc", newPC_out, 16'h0004);
    chk("b2b2_pc2", PC2_out, 16'h0006);

    // redirect with ready drops data and moves pc to 0x0010
    tick(); drive(0, 1, 16'h0010, 1, 16'h7777);
    chk("redir_rdy_instr", instrct_out, NOP);

    // 3-cycle latency at 0x0010
    tick(); drive(0, 0, 0, 0, 16'h0);
    chk("lat0_addr", imem_addr, 16'h0010);
    chk("lat0_instr", instrct_out, NOP);
    chk("lat0_newpc", newPC_out, 16'h0010);
    tick(); drive(1, 0, 0, 0, 16'h0);
    chk("lat1_addr", imem_addr, 16'h0010);
    chk("lat1_req", {15'd0, imem_req}, 16'd1);
    chk("lat1_ifid", {15'd0, ifid_en}, 16'd0);
    tick(); drive(0, 0, 0, 0, 16'h0);
    chk("lat2_addr", imem_addr, 16'h0010);
    tick(); drive(0, 0, 0, 1, 16'h1234);
    chk("lat3_instr", instrct_out, 16'h1234);
    chk("lat3_newpc", newPC_out, 16'h0010);
    chk("lat3_pc2", PC2_out, 16'h0012);

    // stall on ready: capture into HOLD, deliver once stall drops
    tick(); drive(1, 0, 0, 1, 16'hA5A5);
    chk("stl_cap_instr", instrct_out, NOP);
    chk("stl_cap_ifid", {15'd0, ifid_en}, 16'd0);
    tick(); drive(1, 0, 0, 0, 16'h0);
    chk("stl_hold_req", {15'd0, imem_req}, 16'd0);
    chk("stl_hold_instr", instrct_out, NOP);
    tick(); drive(0, 0, 0, 0, 16'h0);
    chk("stl_rel_instr", instrct_out, 16'hA5A5);
    chk("stl_rel_newpc", newPC_out, 16'h0012);
    chk("stl_rel_pc2", PC2_out, 16'h0014);
    chk("stl_rel_req", {15'd0, imem_req}, 16'd0);
    tick(); drive(0, 0, 0, 0, 16'h0);
    chk("stl_next_addr", imem_addr, 16'h0014);
    chk("stl_next_req", {15'd0, imem_req}, 16'd1);
    chk("stl_next_instr", instrct_out, NOP);

    // redirect while request outstanding, ready two cycles later
    drive(1, 1, 16'h0100, 0, 16'h0);
    chk("dis_enter_ifid", {15'd0, ifid_en}, 16'd1);
    chk("dis_enter_instr", instrct_out, NOP);
    tick(); drive(0, 0, 0, 0, 16'h0);
    chk("dis_addr", imem_addr, 16'h0014);
    chk("dis_req", {15'd0, imem_req}, 16'd1);
    tick(); drive(0, 0, 0, 1, 16'hBEEF);
    chk("dis_drop_instr", instrct_out, NOP);
    tick(); drive(0, 0, 0, 0, 16'h0);
    chk("dis_new_addr", imem_addr, 16'h0100);

    // halt instruction, then redirect out of HALTED
    drive(0, 0, 0, 1, 16'h0000);
    chk("halt_instr", instrct_out, 16'h0000);
    chk("halt_newpc", newPC_out, 16'h0100);
    tick(); drive(0, 0, 0, 0, 16'h0);
    chk("halt_flag", {15'd0, halted}, 16'd1);
    chk("halt_req", {15'd0, imem_req}, 16'd0);
    chk("halt_instr_nop", instrct_out, NOP);
    tick(); drive(0, 1, 16'h0040, 0, 16'h0);
    chk("halt_redir_instr", instrct_out, NOP);
    tick(); drive(0, 0, 0, 0, 16'h0);
    chk("resume_addr", imem_addr, 16'h0040);
    chk("resume_halted", {15'd0, halted}, 16'd0);

    // DISCARD: later redirect overrides, same-cycle redirect with ready wins
    drive(0, 1, 16'hFFF0, 0, 16'h0);
    tick(); drive(0, 1, 16'hFFF4, 0, 16'h0);
    tick(); drive(0, 1, 16'hFFFE, 1, 16'h9999);
    chk("dis2_drop_instr", instrct_out, NOP);
    tick(); drive(0, 0, 0, 1, 16'h4444);
    chk("wrap_addr", imem_addr, 16'hFFFE);
    chk("wrap_newpc", newPC_out, 16'hFFFE);
    chk("wrap_pc2", PC2_out, 16'h0000);
    tick(); drive(0, 0, 0, 1, 16'h4555);
    chk("wrap_next_addr", imem_addr, 16'h0000);
    chk("wrap_next_instr", instrct_out, 16'h4555);

    // reset asserted in the middle of DISCARD
    tick(); drive(0, 1, 16'h0200, 0, 16'h0);
    tick(); drive(0, 0, 0, 0, 16'h0);
    chk("rstd_addr_before", imem_addr, 16'h0002);
    rst = 1'b1;
    #1;
    chk("rstd_addr", imem_addr, 16'h0000);
    chk("rstd_req", {15'd0, imem_req}, 16'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rstd_rel_req", {15'd0, imem_req}, 16'd1);
    chk("rstd_rel_addr", imem_addr, 16'h0000);
    drive(0, 0, 0, 1, 16'h4ABC);
    chk("rstd_rel_instr", instrct_out, 16'h4ABC);
    chk("rstd_rel_newpc", newPC_out, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end that produces the instruction and PC values written into the IF/ID pipeline register.
- Owns the PC and runs a request/ready handshake with instruction memory, which may take several cycles.
- Absorbs stalls from the hazard unit and redirects from branch/jump resolution.
- Inserts NOP bubbles whenever no valid instruction is available for IF/ID.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0800, bubble instruction driven to IF/ID.
- HALT_OPC, 5'b00000, opcode in instr[15:11] that stops fetch.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard unit freezes IF/ID and fetch.
- redirect  in  1  taken branch/jump; overrides stall.
- redirect_pc  in  16  target PC, sampled when redirect=1.
- imem_req  out  1  memory request valid.
- imem_addr  out  16  request address; stable while imem_req=1 and imem_ready=0.
- imem_rdata  in  16  instruction; valid when imem_ready=1.
- imem_ready  in  1  single-cycle completion strobe.
- instrct_out  out  16  instruction to IF/ID.
- newPC_out  out  16  address of instrct_out.
- PC2_out  out  16  newPC_out + 2, modulo 2^16.
- ifid_en  out  1  IF/ID write enable, equal to !stall || redirect.
- halted  out  1  high in HALTED state.

Behaviour:
- State register: FETCH, DISCARD, HOLD, HALTED.
- Reset is asynchronous. On reset: state=FETCH, pc=RESET_PC, redir_pc=0, hold buffer={NOP_INSTR,0}, halted=0.
- First imem_req is issued in the cycle after rst deasserts.
- imem_req=1 in FETCH and DISCARD only. imem_addr=pc in FETCH; in DISCARD it holds the address of the outstanding request.
- Delivery: instrct_out/newPC_out/PC2_out are combinational and valid in the same cycle as imem_ready (zero added latency); IF/ID registers them.
- Whenever nothing is being delivered: instrct_out=NOP_INSTR, newPC_out=pc, PC2_out=pc+2.
- FETCH, ready=1:
  - redirect: drop the data, drive NOP, pc<=redirect_pc, stay in FETCH.
  - stall (no redirect): capture {rdata, pc} into the hold buffer, go to HOLD, pc unchanged.
  - rdata[15:11]==HALT_OPC: deliver it, go to HALTED.
  - otherwise: deliver it, pc<=pc+2 (16-bit wrap, 16'hFFFE -> 16'h0000).
- FETCH, ready=0:
  - redirect: redir_pc<=redirect_pc, go to DISCARD.
  - otherwise: hold; stall has no effect on the outstanding request.
- DISCARD:
  - Output is always NOP.
  - A later redirect overwrites redir_pc; the last one wins.
  - On ready: drop the data, pc<=redir_pc, go to FETCH. If a redirect arrives in that same cycle, its target is used instead.
- HOLD:
  - imem_req=0.
  - When stall=0: deliver the buffer, then pc<=pc+2 and go to FETCH, or go to HALTED if the buffer holds a halt.
  - redirect: drop the buffer, pc<=redirect_pc, go to FETCH.
- HALTED:
  - imem_req=0, output NOP, halted=1.
  - redirect: pc<=redirect_pc, go to FETCH; this cancels a speculative halt.
  - Only rst or redirect leaves HALTED.
- redirect always takes priority over stall. stall never drops an instruction.
- Odd redirect_pc is used unmodified; no alignment fixup is applied.

Optional Feature:
- Macro: FETCH_STATS_EN.
- Defined: adds two outputs, stat_fetched (16-bit count of delivered instructions) and stat_bubbles (16-bit count of cycles with ifid_en=1 and NOP driven).
  - Both counters saturate at 16'hFFFF and clear on rst.
- Undefined: no counters and no extra ports. Behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg holds:
  - fetch_state_t enum (FETCH, DISCARD, HOLD, HALTED).
  - NOP_INSTR and HALT_OPC constants.
  - PC_W=16 and INSTR_W=16.
- One sub-module: fetch_hold_buf, a 32-bit {instr, pc} skid register with load/clear and async reset. The FSM, PC and output muxing stay in fetch_stage.

Test Plan:
- Reset, memory ready every cycle, rdata 16'h4001, 16'h4002 … → newPC 0,2,4; PC2 2,4,6; instructions delivered back to back with no bubbles.
- 3-cycle memory latency at pc=16'h0010 → imem_addr holds 16'h0010 for 3 cycles; NOP driven until ready; then instr delivered with newPC=16'h0010, PC2=16'h0012.
- stall=1 in the cycle ready=1 with rdata=16'hA5A5 → HOLD, imem_req=0; after stall drops, 16'hA5A5 is delivered once and the next request goes to pc+2.
- redirect to 16'h0100 while a request is outstanding, ready two cycles later → stale data dropped with NOP driven; next imem_addr=16'h0100.
- rdata=16'h0000 (halt) → delivered once, then halted=1, imem_req=0, NOP; redirect to 16'h0040 → fetch resumes at 16'h0040.
- pc=16'hFFFE delivered → next imem_addr=16'h0000; rst asserted mid-DISCARD → immediately FETCH with imem_addr=RESET_PC.
